// File: rtl/lock_pkg.sv
// lock_pkg: state encoding, key codes and the key encoder shared by the lock
package lock_pkg;
    typedef enum logic [2:0] {ENTRY, CHECK, OPEN, FAIL, LOCKOUT} state_t;
    localparam int         DIGIT_W  = 4;
    localparam logic [3:0] KEY_NONE = 4'd0;
    localparam logic [3:0] KEY_DEL  = 4'd10;
    localparam logic [3:0] KEY_CLR  = 4'd11;
    // Clear beats delete beats digit; a digit needs exactly one low key line
    function automatic logic [3:0] key_encode(input logic [8:0] key_low, input logic del, input logic clr);
        logic [3:0] code;
        code = KEY_NONE;
        for (int i = 0; i < 9; i++)
            if (key_low == 9'(1 << i)) code = 4'(i + 1);
        if (del) code = KEY_DEL;
        if (clr) code = KEY_CLR;
        return code;
    endfunction
endpackage

// File: rtl/lock_key_event.sv
// lock_key_event: registers raw keys, encodes them and pulses on NONE->valid transitions
module lock_key_event
    import lock_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [8:0] key_n,
    input  logic       del_key,
    input  logic       clr_key,
    output logic [3:0] key_code,
    output logic       key_valid
);
    logic [8:0] r_key_n;
    logic       r_del;
    logic       r_clr;
    logic [3:0] r_prev;
    logic [3:0] w_code;

    assign w_code    = key_encode(~r_key_n, r_del, r_clr);
    assign key_code  = w_code;
    assign key_valid = (r_prev == KEY_NONE) && (w_code != KEY_NONE);

    // Single input register stage plus last code, so a held key fires only once
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_key_n <= '1;
            r_del   <= 1'b0;
            r_clr   <= 1'b0;
            r_prev  <= KEY_NONE;
        end else begin
            r_key_n <= key_n;
            r_del   <= del_key;
            r_clr   <= clr_key;
            r_prev  <= w_code;
        end
    end
endmodule

// File: rtl/lock_fsm_param.sv
// lock_fsm_param: parametrised keypad lock; define LOCK_TIMEOUT_EN to let lockout expire after LOCK_CYCLES
module lock_fsm_param
    import lock_pkg::*;
#(
    parameter int                      DIGITS      = 4,
    parameter int                      MAX_FAIL    = 3,
    parameter int                      HOLD_CYCLES = 50_000_000,
    parameter int                      LOCK_CYCLES = 500_000_000,
    parameter logic [4*DIGITS-1:0]     INIT_PWD    = 16'h1234
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [8:0]                 key_n,
    input  logic                       del_key,
    input  logic                       clr_key,
    input  logic                       set_mode,
    output logic [4*DIGITS-1:0]        digit_buf,
    output logic [3:0]                 digit_cnt,
    output logic                       success,
    output logic                       failed,
    output logic                       locked_out,
    output logic                       pwd_updated
);
    localparam int W    = DIGIT_W * DIGITS;
    localparam int CMAX = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
    localparam int TW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    state_t         r_state, w_state;
    logic [W-1:0]   r_buf, w_buf, r_pwd, w_pwd, w_buf_add, w_buf_del;
    logic [3:0]     r_cnt, w_cnt, r_fail, w_fail;
    logic [TW-1:0]  r_timer, w_timer;
    logic           r_pwd_upd, w_pwd_upd;
    logic [3:0]     w_code;
    logic           w_valid, w_dig, w_del, w_clr, w_last;

    lock_key_event u_key (
        .clock     (clock),
        .reset_n   (reset_n),
        .key_n     (key_n),
        .del_key   (del_key),
        .clr_key   (clr_key),
        .key_code  (w_code),
        .key_valid (w_valid)
    );

    assign w_dig     = w_valid && (w_code <= 4'd9);
    assign w_del     = w_valid && (w_code == KEY_DEL) && (r_cnt != 4'd0);
    assign w_clr     = w_valid && (w_code == KEY_CLR);
    assign w_last    = (r_cnt == 4'(DIGITS - 1));
    assign w_buf_add = r_buf | (W'(w_code) << (DIGIT_W * (DIGITS - 1 - int'(r_cnt))));
    assign w_buf_del = r_buf & ~(W'(4'hF) << (DIGIT_W * (DIGITS - int'(r_cnt))));

    assign digit_buf   = r_buf;
    assign digit_cnt   = r_cnt;
    assign success     = (r_state == OPEN);
    assign failed      = (r_state == FAIL);
    assign locked_out  = (r_state == LOCKOUT);
    assign pwd_updated = r_pwd_upd;

    // State register and datapath registers; reset restores the factory password
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ENTRY;
            r_buf     <= '0;
            r_cnt     <= 4'd0;
            r_fail    <= 4'd0;
            r_pwd     <= INIT_PWD;
            r_timer   <= '0;
            r_pwd_upd <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_buf     <= w_buf;
            r_cnt     <= w_cnt;
            r_fail    <= w_fail;
            r_pwd     <= w_pwd;
            r_timer   <= w_timer;
            r_pwd_upd <= w_pwd_upd;
        end
    end

    // Next state and buffer edits; the last digit of an entry moves straight to CHECK
    always_comb begin
        w_state   = r_state;
        w_buf     = r_buf;
        w_cnt     = r_cnt;
        w_fail    = r_fail;
        w_pwd     = r_pwd;
        w_timer   = r_timer;
        w_pwd_upd = 1'b0;
        case (r_state)
            ENTRY: begin
                if (w_clr) begin
                    w_buf = '0;
                    w_cnt = 4'd0;
                end else if (w_del) begin
                    w_buf = w_buf_del;
                    w_cnt = r_cnt - 4'd1;
                end else if (w_dig) begin
                    w_buf = w_buf_add;
                    w_cnt = r_cnt + 4'd1;
                    if (w_last) w_state = CHECK;
                end
            end
            CHECK: begin
                w_timer = '0;
                if (r_buf == r_pwd) begin
                    w_state = OPEN;
                    w_fail  = 4'd0;
                    w_buf   = '0;
                    w_cnt   = 4'd0;
                end else begin
                    w_fail  = r_fail + 4'd1;
                    w_state = (w_fail == 4'(MAX_FAIL)) ? LOCKOUT : FAIL;
                end
            end
            OPEN: begin
                if (w_clr) begin
                    w_state = ENTRY;
                    w_buf   = '0;
                    w_cnt   = 4'd0;
                end else if (!set_mode) begin
                    w_buf = '0;
                    w_cnt = 4'd0;
                end else if (w_del) begin
                    w_buf = w_buf_del;
                    w_cnt = r_cnt - 4'd1;
                end else if (w_dig) begin
                    w_pwd     = w_last ? w_buf_add : r_pwd;
                    w_pwd_upd = w_last;
                    w_buf     = w_last ? '0 : w_buf_add;
                    w_cnt     = w_last ? 4'd0 : r_cnt + 4'd1;
                end
            end
            FAIL: begin
                if (r_timer == TW'(HOLD_CYCLES - 1)) begin
                    w_state = ENTRY;
                    w_buf   = '0;
                    w_cnt   = 4'd0;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            LOCKOUT: begin
`ifdef LOCK_TIMEOUT_EN
                if (r_timer == TW'(LOCK_CYCLES - 1)) begin
                    w_state = ENTRY;
                    w_fail  = 4'd0;
                    w_buf   = '0;
                    w_cnt   = 4'd0;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
`else
                w_state = LOCKOUT;
`endif
            end
            default: w_state = ENTRY;
        endcase
    end
endmodule

// File: tb/tb_lock_fsm_param.sv
// tb_lock_fsm_param: directed checks of entry, editing, failure/lockout, re-keying and key edges
module tb_lock_fsm_param;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [8:0]  key_n;
    logic        del_key, clr_key, set_mode;
    logic [15:0] digit_buf;
    logic [3:0]  digit_cnt;
    logic        success, failed, locked_out, pwd_updated;
    int          n_cmp = 0;
    int          n_bad = 0;

    lock_fsm_param #(
        .DIGITS(4), .MAX_FAIL(3), .HOLD_CYCLES(4), .LOCK_CYCLES(10), .INIT_PWD(16'h1234)
    ) dut (
        .clock(clock), .reset_n(reset_n), .key_n(key_n), .del_key(del_key), .clr_key(clr_key),
        .set_mode(set_mode), .digit_buf(digit_buf), .digit_cnt(digit_cnt), .success(success),
        .failed(failed), .locked_out(locked_out), .pwd_updated(pwd_updated)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // k: 1..9 digit, 10 delete, 11 clear; returns once the buffer reflects the key
    task automatic press(input int k);
        if (k == 11) clr_key = 1'b1;
        else if (k == 10) del_key = 1'b1;
        else key_n[k-1] = 1'b0;
        tick(1);
        key_n = '1;
        del_key = 1'b0;
        clr_key = 1'b0;
        tick(1);
    endtask

    task automatic enter(input logic [15:0] code);
        for (int i = 0; i < 4; i++) press(int'(code[15-4*i -: 4]));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        key_n = '1;
        del_key = 1'b0;
        clr_key = 1'b0;
        set_mode = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        key_n = '1;
        del_key = 1'b0;
        clr_key = 1'b0;
        set_mode = 1'b0;
        tick(2);
        n_cmp++; if ({digit_buf, digit_cnt, success, failed, locked_out, pwd_updated} !== 24'h0) begin n_bad++; $display("FAIL reset_outs: got %h want 000000", {digit_buf, digit_cnt, success, failed, locked_out, pwd_updated}); end
        reset_n = 1'b1;
        tick(2);
        n_cmp++; if ({digit_buf, digit_cnt, success, failed, locked_out, pwd_updated} !== 24'h0) begin n_bad++; $display("FAIL idle_outs: got %h want 000000", {digit_buf, digit_cnt, success, failed, locked_out, pwd_updated}); end
    endtask

    task automatic test_open();
        do_reset();
        enter(16'h1234);
        n_cmp++; if (digit_buf !== 16'h1234 || digit_cnt !== 4'd4) begin n_bad++; $display("FAIL open_buf: got %h/%0d want 1234/4", digit_buf, digit_cnt); end
        n_cmp++; if (success !== 1'b0) begin n_bad++; $display("FAIL open_early: got %b want 0", success); end
        tick(1);
        n_cmp++; if (success !== 1'b1 || digit_buf !== 16'h0) begin n_bad++; $display("FAIL open_success: got %b/%h want 1/0000", success, digit_buf); end
        press(11);
        n_cmp++; if (success !== 1'b0) begin n_bad++; $display("FAIL open_relock: got %b want 0", success); end
    endtask

    task automatic test_edit();
        do_reset();
        press(1); press(2); press(10); press(5);
        n_cmp++; if (digit_buf !== 16'h1500 || digit_cnt !== 4'd2) begin n_bad++; $display("FAIL edit_del: got %h/%0d want 1500/2", digit_buf, digit_cnt); end
        press(11);
        n_cmp++; if (digit_buf !== 16'h0 || digit_cnt !== 4'd0) begin n_bad++; $display("FAIL edit_clr: got %h/%0d want 0000/0", digit_buf, digit_cnt); end
        press(10);
        n_cmp++; if (digit_buf !== 16'h0 || digit_cnt !== 4'd0) begin n_bad++; $display("FAIL edit_del_empty: got %h/%0d want 0000/0", digit_buf, digit_cnt); end
    endtask

    task automatic test_lockout();
        int hi;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            enter(16'h9999);
            hi = 0;
            for (int c = 0; c < 8; c++) begin tick(1); hi += int'(failed); end
            n_cmp++; if (hi != 4) begin n_bad++; $display("FAIL fail_hold%0d: got %0d cycles want 4", r, hi); end
        end
        enter(16'h9999);
        tick(1);
        n_cmp++; if (locked_out !== 1'b1 || failed !== 1'b0) begin n_bad++; $display("FAIL lockout_enter: got %b/%b want 1/0", locked_out, failed); end
`ifdef LOCK_TIMEOUT_EN
        hi = 0;
        for (int c = 0; c < 14; c++) begin hi += int'(locked_out); tick(1); end
        n_cmp++; if (hi != 10) begin n_bad++; $display("FAIL lock_time: got %0d cycles want 10", hi); end
        enter(16'h1234);
        tick(1);
        n_cmp++; if (success !== 1'b1) begin n_bad++; $display("FAIL lock_reopen: got %b want 1", success); end
`else
        enter(16'h1234);
        tick(20);
        n_cmp++; if (locked_out !== 1'b1 || success !== 1'b0 || digit_buf !== 16'h9999) begin n_bad++; $display("FAIL lock_hold: got %b/%b/%h want 1/0/9999", locked_out, success, digit_buf); end
`endif
        do_reset();
        n_cmp++; if (locked_out !== 1'b0 || digit_buf !== 16'h0) begin n_bad++; $display("FAIL lock_reset: got %b/%h want 0/0000", locked_out, digit_buf); end
    endtask

    task automatic test_set_password();
        int hi;
        do_reset();
        enter(16'h1234);
        tick(1);
        press(5);
        n_cmp++; if (digit_buf !== 16'h0) begin n_bad++; $display("FAIL set_ignore: got %h want 0000", digit_buf); end
        set_mode = 1'b1;
        press(5); press(6); press(7);
        n_cmp++; if (digit_buf !== 16'h5670 || digit_cnt !== 4'd3) begin n_bad++; $display("FAIL set_partial: got %h/%0d want 5670/3", digit_buf, digit_cnt); end
        press(8);
        n_cmp++; if (pwd_updated !== 1'b1 || digit_buf !== 16'h0 || success !== 1'b1) begin n_bad++; $display("FAIL set_pulse: got %b/%h/%b want 1/0000/1", pwd_updated, digit_buf, success); end
        tick(1);
        n_cmp++; if (pwd_updated !== 1'b0) begin n_bad++; $display("FAIL set_pulse_len: got %b want 0", pwd_updated); end
        press(4);
        set_mode = 1'b0;
        tick(1);
        n_cmp++; if (digit_buf !== 16'h0) begin n_bad++; $display("FAIL set_drop: got %h want 0000", digit_buf); end
        press(11);
        enter(16'h1234);
        tick(1);
        n_cmp++; if (failed !== 1'b1) begin n_bad++; $display("FAIL old_pwd: got %b want 1", failed); end
        hi = 0;
        for (int c = 0; c < 8 && failed; c++) begin tick(1); hi++; end
        enter(16'h5678);
        tick(1);
        n_cmp++; if (success !== 1'b1) begin n_bad++; $display("FAIL new_pwd: got %b want 1", success); end
        do_reset();
        enter(16'h1234);
        tick(1);
        n_cmp++; if (success !== 1'b1) begin n_bad++; $display("FAIL pwd_restore: got %b want 1", success); end
    endtask

    task automatic test_key_edges();
        do_reset();
        key_n[0] = 1'b0;
        tick(20);
        key_n = '1;
        tick(2);
        n_cmp++; if (digit_buf !== 16'h1000 || digit_cnt !== 4'd1) begin n_bad++; $display("FAIL held_key: got %h/%0d want 1000/1", digit_buf, digit_cnt); end
        key_n = 9'b111111100;
        tick(3);
        key_n = '1;
        tick(2);
        n_cmp++; if (digit_buf !== 16'h1000 || digit_cnt !== 4'd1) begin n_bad++; $display("FAIL multi_key: got %h/%0d want 1000/1", digit_buf, digit_cnt); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        press(7); press(3);
        n_cmp++; if (digit_buf !== 16'h7300) begin n_bad++; $display("FAIL mid_pre: got %h want 7300", digit_buf); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (digit_buf !== 16'h0 || digit_cnt !== 4'd0) begin n_bad++; $display("FAIL mid_reset: got %h/%0d want 0000/0", digit_buf, digit_cnt); end
        tick(1);
        reset_n = 1'b1;
        tick(1);
        enter(16'h1234);
        tick(1);
        n_cmp++; if (success !== 1'b1) begin n_bad++; $display("FAIL mid_after: got %b want 1", success); end
    endtask

    initial begin
        test_reset();
        test_open();
        test_edit();
        test_lockout();
        test_set_password();
        test_key_edges();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
